layer_inter_pingpong_control: RTL

//  Parametrised multi-bank (ping-pong) buffer controller between a producer conv layer and a consumer fc layer.
//  The producer fills bank N while the consumer reads bank N-1, so the two layers overlap instead of serialising.

---
 rtl/layer_inter_pingpong_control_pkg.sv | 24 ++
 rtl/layer_inter_pingpong_control_bank_port_mux.sv | 47 ++++
 rtl/layer_inter_pingpong_control.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_inter_pingpong_control_pkg.sv
// Shared definitions for the ping-pong buffer controller.
//   - prod_state_t / cons_state_t : producer and consumer FSM states
//   - bank_ptr_wrap()             : advance a bank pointer modulo the bank count,
//                                   valid for non-power-of-two bank counts
package layer_inter_pingpong_control_pkg;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_RUN  = 1'b1
    } prod_state_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } cons_state_t;

    // Explicit compare-and-reset rather than a modulo so that three, five, ...
    // banks wrap correctly without a divider.
    function automatic int unsigned bank_ptr_wrap(input int unsigned ptr,
                                                  input int unsigned num_banks);
        return (ptr == num_banks - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/layer_inter_pingpong_control_bank_port_mux.sv
// layer_bank_port_mux
// Decodes one layer's memory-port controls onto NUM_BANKS per-bank ports.
// Only the bank selected by i_bank receives the controls, and only while
// i_active is high; every other bank sees all-zero controls and addresses.
// Ports:
//   i_active                 : this layer currently owns its bank
//   i_bank                   : selected bank index
//   i_rden_a/b, i_wren_a/b   : port-A/B read and write enables
//   i_address_a/b            : port-A/B addresses
//   o_rden_a/b, o_wren_a/b   : per-bank enables, bit i = bank i
//   o_address_a/b            : per-bank addresses, slice i = bank i
module layer_bank_port_mux
    import layer_inter_pingpong_control_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int BANK_W     = 1,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                            i_active,
    input  logic [BANK_W-1:0]               i_bank,
    input  logic                            i_rden_a,
    input  logic                            i_rden_b,
    input  logic                            i_wren_a,
    input  logic                            i_wren_b,
    input  logic [ADDR_WIDTH-1:0]           i_address_a,
    input  logic [ADDR_WIDTH-1:0]           i_address_b,
    output logic [NUM_BANKS-1:0]            o_rden_a,
    output logic [NUM_BANKS-1:0]            o_rden_b,
    output logic [NUM_BANKS-1:0]            o_wren_a,
    output logic [NUM_BANKS-1:0]            o_wren_b,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] o_address_a,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] o_address_b
);

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : gen_bank
        logic w_sel;
        assign w_sel = i_active && (i_bank == BANK_W'(gi));

        assign o_rden_a[gi] = w_sel & i_rden_a;
        assign o_rden_b[gi] = w_sel & i_rden_b;
        assign o_wren_a[gi] = w_sel & i_wren_a;
        assign o_wren_b[gi] = w_sel & i_wren_b;
        assign o_address_a[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_sel ? i_address_a : '0;
        assign o_address_b[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_sel ? i_address_b : '0;
    end

endmodule

// File: rtl/layer_inter_pingpong_control.sv
// layer_inter_pingpong_control
// Multi-bank ping-pong buffer controller between a producer layer (writes a
// frame into bank wr_bank) and a consumer layer (reads bank rd_bank), letting
// the two layers overlap. Sequences both layers' run enables and start pulses,
// tracks how many banks hold unread frames, and routes each layer's memory
// port controls to the bank it owns. Optionally a new consumer frame needs a
// credit returned by the downstream layer (layer_nextnext_done).
// Ports:
//   i_clock, i_reset                 : clock, synchronous active-high reset
//   i_enable                         : 0 = no new frame starts (running frames finish)
//   i_layer_former_done              : producer frame done (rising edge acts)
//   i_layer_next_done                : consumer frame done (rising edge acts)
//   i_layer_nextnext_done            : downstream frame done (rising edge = credit)
//   o_layer_former_enable/_reset     : producer run enable / first-cycle pulse
//   o_layer_next_enable/_reset       : consumer run enable / first-cycle pulse
//   i_*_layer_former                 : producer port-A/B rden, wren, address
//   i_*_layer_next                   : consumer port-A/B rden, address
//   o_bank_rden/wren_a/b             : per-bank enables, bit i = bank i
//   o_bank_address_a/b               : per-bank addresses, slice i = bank i
//   o_wr_bank, o_rd_bank             : producer / consumer bank pointers
//   o_full_count                     : banks holding unread frames
module layer_inter_pingpong_control
    import layer_inter_pingpong_control_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_BANKS     = 2,
    parameter int BANK_W        = $clog2(NUM_BANKS),
    parameter int WAIT_NEXTNEXT = 1
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_layer_former_done,
    input  logic                            i_layer_next_done,
    input  logic                            i_layer_nextnext_done,
    output logic                            o_layer_former_enable,
    output logic                            o_layer_former_reset,
    output logic                            o_layer_next_enable,
    output logic                            o_layer_next_reset,
    input  logic                            i_rden_a_layer_former,
    input  logic                            i_rden_b_layer_former,
    input  logic                            i_wren_a_layer_former,
    input  logic                            i_wren_b_layer_former,
    input  logic [ADDR_WIDTH-1:0]           i_address_a_layer_former,
    input  logic [ADDR_WIDTH-1:0]           i_address_b_layer_former,
    input  logic                            i_rden_a_layer_next,
    input  logic                            i_rden_b_layer_next,
    input  logic [ADDR_WIDTH-1:0]           i_address_a_layer_next,
    input  logic [ADDR_WIDTH-1:0]           i_address_b_layer_next,
    output logic [NUM_BANKS-1:0]            o_bank_rden_a,
    output logic [NUM_BANKS-1:0]            o_bank_rden_b,
    output logic [NUM_BANKS-1:0]            o_bank_wren_a,
    output logic [NUM_BANKS-1:0]            o_bank_wren_b,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] o_bank_address_a,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] o_bank_address_b,
    output logic [BANK_W-1:0]               o_wr_bank,
    output logic [BANK_W-1:0]               o_rd_bank,
    output logic [BANK_W:0]                 o_full_count
);

    localparam logic [BANK_W:0] L_NUM_BANKS = (BANK_W+1)'(NUM_BANKS);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    prod_state_t       r_p_state;
    cons_state_t       r_c_state;
    logic [BANK_W-1:0] r_wr_bank;
    logic [BANK_W-1:0] r_rd_bank;
    logic [BANK_W:0]   r_full_count;
    logic              r_credit;
    logic              r_former_done_d;
    logic              r_next_done_d;
    logic              r_nextnext_done_d;
    logic              r_p_run_d;
    logic              r_c_run_d;

    prod_state_t       w_p_state_next;
    cons_state_t       w_c_state_next;
    logic [BANK_W-1:0] w_wr_bank_next;
    logic [BANK_W-1:0] w_rd_bank_next;
    logic [BANK_W:0]   w_full_count_next;
    logic              w_credit_next;

    logic w_former_edge;
    logic w_next_edge;
    logic w_nextnext_edge;
    logic w_p_run;
    logic w_c_run;
    logic w_prod_done;
    logic w_cons_done;
    logic w_cons_start;
    logic w_credit_ok;

    // Only rising edges of the done levels act; a level held high is ignored.
    assign w_former_edge   = i_layer_former_done   & ~r_former_done_d;
    assign w_next_edge     = i_layer_next_done     & ~r_next_done_d;
    assign w_nextnext_edge = i_layer_nextnext_done & ~r_nextnext_done_d;

    assign w_p_run     = (r_p_state == P_RUN);
    assign w_c_run     = (r_c_state == C_RUN);
    // Done edges arriving while the FSM is idle are dropped here.
    assign w_prod_done = w_p_run & w_former_edge;
    assign w_cons_done = w_c_run & w_next_edge;
    assign w_credit_ok = r_credit || (WAIT_NEXTNEXT == 0);

    // ------------------------------------------------------------------
    // FSM next-state and bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_p_state_next    = r_p_state;
        w_c_state_next    = r_c_state;
        w_cons_start      = 1'b0;
        w_full_count_next = r_full_count;
        w_wr_bank_next    = r_wr_bank;
        w_rd_bank_next    = r_rd_bank;
        w_credit_next     = r_credit;

        case (r_p_state)
            P_IDLE:  if (i_enable && (r_full_count < L_NUM_BANKS)) w_p_state_next = P_RUN;
            P_RUN:   if (w_former_edge) w_p_state_next = P_IDLE;
            default: w_p_state_next = P_IDLE;
        endcase

        case (r_c_state)
            C_IDLE: begin
                if (i_enable && (r_full_count != '0) && w_credit_ok) begin
                    w_c_state_next = C_RUN;
                    w_cons_start   = 1'b1;
                end
            end
            C_RUN:   if (w_next_edge) w_c_state_next = C_IDLE;
            default: w_c_state_next = C_IDLE;
        endcase

        // Simultaneous produce and consume cancel out in the count.
        case ({w_prod_done, w_cons_done})
            2'b10:   w_full_count_next = r_full_count + 1'b1;
            2'b01:   w_full_count_next = r_full_count - 1'b1;
            default: w_full_count_next = r_full_count;
        endcase

        if (w_prod_done) w_wr_bank_next = BANK_W'(bank_ptr_wrap(32'(r_wr_bank), NUM_BANKS));
        if (w_cons_done) w_rd_bank_next = BANK_W'(bank_ptr_wrap(32'(r_rd_bank), NUM_BANKS));

        // A credit arriving in the same cycle the consumer starts is kept
        // for the following frame.
        if (w_nextnext_edge)   w_credit_next = 1'b1;
        else if (w_cons_start) w_credit_next = 1'b0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_p_state         <= P_IDLE;
            r_c_state         <= C_IDLE;
            r_wr_bank         <= '0;
            r_rd_bank         <= '0;
            r_full_count      <= '0;
            r_credit          <= 1'b1;
            r_former_done_d   <= 1'b0;
            r_next_done_d     <= 1'b0;
            r_nextnext_done_d <= 1'b0;
            r_p_run_d         <= 1'b0;
            r_c_run_d         <= 1'b0;
        end else begin
            r_p_state         <= w_p_state_next;
            r_c_state         <= w_c_state_next;
            r_wr_bank         <= w_wr_bank_next;
            r_rd_bank         <= w_rd_bank_next;
            r_full_count      <= w_full_count_next;
            r_credit          <= w_credit_next;
            r_former_done_d   <= i_layer_former_done;
            r_next_done_d     <= i_layer_next_done;
            r_nextnext_done_d <= i_layer_nextnext_done;
            r_p_run_d         <= w_p_run;
            r_c_run_d         <= w_c_run;
        end
    end

    assign o_layer_former_enable = w_p_run;
    assign o_layer_former_reset  = w_p_run & ~r_p_run_d;
    assign o_layer_next_enable   = w_c_run;
    assign o_layer_next_reset    = w_c_run & ~r_c_run_d;
    assign o_wr_bank             = r_wr_bank;
    assign o_rd_bank             = r_rd_bank;
    assign o_full_count          = r_full_count;

    // ------------------------------------------------------------------
    // Bank routing
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0]            w_p_rden_a, w_p_rden_b, w_p_wren_a, w_p_wren_b;
    logic [NUM_BANKS-1:0]            w_c_rden_a, w_c_rden_b, w_c_wren_a, w_c_wren_b;
    logic [NUM_BANKS*ADDR_WIDTH-1:0] w_p_addr_a, w_p_addr_b, w_c_addr_a, w_c_addr_b;
    logic                            w_c_route;

    // Should both layers ever claim the same bank, the consumer is masked so
    // the producer's controls reach the memory unmixed.
    assign w_c_route = w_c_run && !(w_p_run && (r_wr_bank == r_rd_bank));

    layer_bank_port_mux #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_W     (BANK_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prod_mux (
        .i_active    (w_p_run),
        .i_bank      (r_wr_bank),
        .i_rden_a    (i_rden_a_layer_former),
        .i_rden_b    (i_rden_b_layer_former),
        .i_wren_a    (i_wren_a_layer_former),
        .i_wren_b    (i_wren_b_layer_former),
        .i_address_a (i_address_a_layer_former),
        .i_address_b (i_address_b_layer_former),
        .o_rden_a    (w_p_rden_a),
        .o_rden_b    (w_p_rden_b),
        .o_wren_a    (w_p_wren_a),
        .o_wren_b    (w_p_wren_b),
        .o_address_a (w_p_addr_a),
        .o_address_b (w_p_addr_b)
    );

    // The consumer only reads, so its write enables are tied off.
    layer_bank_port_mux #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_W     (BANK_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cons_mux (
        .i_active    (w_c_route),
        .i_bank      (r_rd_bank),
        .i_rden_a    (i_rden_a_layer_next),
        .i_rden_b    (i_rden_b_layer_next),
        .i_wren_a    (1'b0),
        .i_wren_b    (1'b0),
        .i_address_a (i_address_a_layer_next),
        .i_address_b (i_address_b_layer_next),
        .o_rden_a    (w_c_rden_a),
        .o_rden_b    (w_c_rden_b),
        .o_wren_a    (w_c_wren_a),
        .o_wren_b    (w_c_wren_b),
        .o_address_a (w_c_addr_a),
        .o_address_b (w_c_addr_b)
    );

    assign o_bank_rden_a    = w_p_rden_a | w_c_rden_a;
    assign o_bank_rden_b    = w_p_rden_b | w_c_rden_b;
    assign o_bank_wren_a    = w_p_wren_a | w_c_wren_a;
    assign o_bank_wren_b    = w_p_wren_b | w_c_wren_b;
    assign o_bank_address_a = w_p_addr_a | w_c_addr_a;
    assign o_bank_address_b = w_p_addr_b | w_c_addr_b;

    // The full_count bookkeeping keeps the two layers on different banks.
    a_no_bank_collision: assert property (@(posedge i_clock) disable iff (i_reset)
        !(w_p_run && w_c_run && (r_wr_bank == r_rd_bank)));

endmodule
